// File: rtl/bo_delay_queue.sv
// Delay queue for the best-offset prefetcher: each pushed tag is held DELAY cycles before it
// is offered on cq_out. Optional statistics ports are compiled in with BO_DQ_STATS_EN.
module bo_delay_queue #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 15,
    parameter int DELAY     = 60,
    parameter int TIME_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cq_enq,
    input  logic                     cq_deq,
    input  logic [WIDTH-1:0]         cq_in,
    output logic                     cq_empty,
    output logic                     cq_full,
    output logic                     cq_ready,
    output logic [WIDTH-1:0]         cq_out
`ifdef BO_DQ_STATS_EN
    ,
    output logic [15:0]              dq_drop_cnt,
    output logic [$clog2(DEPTH+1)-1:0] dq_occupancy
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0]     head;
    logic [IDX_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic [TIME_BITS-1:0] now;
    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     matured;
    logic [DEPTH-1:0]     aged;
    logic [WIDTH-1:0]     tag   [DEPTH];
    logic [TIME_BITS-1:0] stamp [DEPTH];
    logic [TIME_BITS-1:0] age;
    logic                 pop;
    logic                 push;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Modular age keeps the comparison correct across timestamp wrap.
    always_comb begin
        age  = '0;
        aged = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age     = now - stamp[i];
            aged[i] = valid[i] && (age >= TIME_BITS'(DELAY));
        end
    end

    assign cq_ready = valid[head] & (matured[head] | aged[head]);
    assign cq_out   = (count != '0) ? tag[head] : '0;

    assign pop  = cq_deq & cq_ready;
    // A pop in the same cycle frees a slot, so a push into a full queue is accepted.
    assign push = cq_enq & (~cq_full | pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            now      <= '0;
            valid    <= '0;
            matured  <= '0;
            cq_empty <= 1'b1;
            cq_full  <= 1'b0;
        end else begin
            now      <= now + 1'b1;
            count    <= count_next;
            cq_empty <= (count_next == '0);
            cq_full  <= (count_next == CNT_W'(DEPTH));
            // Sticky so an entry idle longer than the stamp range never reads as young again.
            for (int i = 0; i < DEPTH; i++) begin
                if (aged[i]) matured[i] <= 1'b1;
            end
            if (pop) begin
                valid[head]   <= 1'b0;
                matured[head] <= 1'b0;
                head          <= next_idx(head);
            end
            if (push) begin
                valid[tail]   <= 1'b1;
                matured[tail] <= 1'b0;
                tail          <= next_idx(tail);
            end
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            tag[tail]   <= cq_in;
            stamp[tail] <= now;
        end
    end

`ifdef BO_DQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_drop_cnt <= '0;
        end else if (cq_enq && !push && dq_drop_cnt != 16'hFFFF) begin
            dq_drop_cnt <= dq_drop_cnt + 16'd1;
        end
    end

    assign dq_occupancy = count;
`endif

endmodule

// File: tb/tb_bo_delay_queue.sv
// Directed bench for bo_delay_queue at default parameters (WIDTH 12, DEPTH 15, DELAY 60, TIME_BITS 12).
// Define BO_DQ_STATS_EN for both files to also check the statistics ports.
module tb_bo_delay_queue;

    localparam int WIDTH = 12;
    localparam int DEPTH = 15;
    localparam int DELAY = 60;

    logic             clk = 1'b0;
    logic             rst;
    logic             cq_enq;
    logic             cq_deq;
    logic [WIDTH-1:0] cq_in;
    logic             cq_empty;
    logic             cq_full;
    logic             cq_ready;
    logic [WIDTH-1:0] cq_out;
`ifdef BO_DQ_STATS_EN
    logic [15:0]      dq_drop_cnt;
    logic [3:0]       dq_occupancy;
`endif

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_q[$];

    bo_delay_queue dut (
        .clk      (clk),
        .rst      (rst),
        .cq_enq   (cq_enq),
        .cq_deq   (cq_deq),
        .cq_in    (cq_in),
        .cq_empty (cq_empty),
        .cq_full  (cq_full),
        .cq_ready (cq_ready),
        .cq_out   (cq_out)
`ifdef BO_DQ_STATS_EN
        ,
        .dq_drop_cnt  (dq_drop_cnt),
        .dq_occupancy (dq_occupancy)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        cq_enq = 1'b0;
        cq_deq = 1'b0;
        cq_in  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_tags(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            cq_in  = base + WIDTH'(i);
            cq_enq = 1'b1;
            step();
        end
        cq_enq = 1'b0;
    endtask

    // Push one tag, then require ready low for DELAY-1 samples and high at the DELAY-th.
    task automatic push_and_time(input logic [WIDTH-1:0] t, input string name);
        int bad_j;
        bad_j  = -1;
        cq_in  = t;
        cq_enq = 1'b1;
        step();
        cq_enq = 1'b0;
        for (int j = 0; j < DELAY - 1; j++) begin
            if (cq_ready !== 1'b0 && bad_j < 0) bad_j = j;
            step();
        end
        checks++;
        if (bad_j >= 0) begin
            errors++;
            $display("FAIL %s_early: cq_ready=1 at %0d cycles after push, required 0 before %0d", name, bad_j + 1, DELAY);
        end
        checks++;
        if (cq_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: cq_ready=%b at %0d cycles after push, required 1", name, cq_ready, DELAY);
        end
        checks++;
        if (cq_out !== t) begin
            errors++;
            $display("FAIL %s_out: cq_out=%h required %h", name, cq_out, t);
        end
    endtask

    // Scoreboard drain: hold deq, compare each popped head with exp_q in order.
    task automatic drain(input string name, input int budget);
        int cycles;
        cycles = 0;
        cq_deq = 1'b1;
        while (exp_q.size() != 0 && cycles < budget) begin
            if (cq_ready === 1'b1) begin
                checks++;
                if (cq_out !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s_order: cq_out=%h required %h", name, cq_out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            step();
            cycles++;
        end
        cq_deq = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d entries never output, required 0", name, exp_q.size());
        end
        exp_q.delete();
        checks++;
        if (cq_empty !== 1'b1 || cq_out !== '0) begin
            errors++;
            $display("FAIL %s_empty: cq_empty=%b cq_out=%h required 1/000", name, cq_empty, cq_out);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({cq_empty, cq_full, cq_ready} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: empty/full/ready=%b required 100", {cq_empty, cq_full, cq_ready});
        end
        checks++;
        if (cq_out !== '0) begin
            errors++;
            $display("FAIL reset_out: cq_out=%h required 000", cq_out);
        end
`ifdef BO_DQ_STATS_EN
        checks++;
        if (dq_drop_cnt !== 16'd0 || dq_occupancy !== 4'd0) begin
            errors++;
            $display("FAIL reset_stats: drop=%0d occ=%0d required 0/0", dq_drop_cnt, dq_occupancy);
        end
`endif
    endtask

    task automatic test_basic_delay();
        do_reset();
        push_and_time(12'hABC, "basic");
        cq_deq = 1'b1;
        step();
        cq_deq = 1'b0;
        checks++;
        if (cq_empty !== 1'b1 || cq_ready !== 1'b0 || cq_out !== '0) begin
            errors++;
            $display("FAIL basic_pop: empty=%b ready=%b out=%h required 1/0/000", cq_empty, cq_ready, cq_out);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        push_tags(12'h100, 14);
        checks++;
        if (cq_full !== 1'b0) begin
            errors++;
            $display("FAIL fill_14: cq_full=%b required 0", cq_full);
        end
        push_tags(12'h10E, 1);
        checks++;
        if (cq_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_15: cq_full=%b required 1", cq_full);
        end
        push_tags(12'h10F, 1);
        checks++;
        if (cq_full !== 1'b1 || cq_out !== 12'h100) begin
            errors++;
            $display("FAIL overflow_hold: full=%b out=%h required 1/100", cq_full, cq_out);
        end
`ifdef BO_DQ_STATS_EN
        checks++;
        if (dq_drop_cnt !== 16'd1 || dq_occupancy !== 4'd15) begin
            errors++;
            $display("FAIL overflow_stats: drop=%0d occ=%0d required 1/15", dq_drop_cnt, dq_occupancy);
        end
`endif
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(12'h100 + WIDTH'(i));
        drain("overflow", 200);
    endtask

    task automatic test_order_wrap();
        do_reset();
        push_tags(12'h001, 15);
        for (int i = 1; i <= 15; i++) exp_q.push_back(WIDTH'(i));
        drain("order", 200);
        push_tags(12'h010, 5);
        for (int i = 0; i < 5; i++) exp_q.push_back(12'h010 + WIDTH'(i));
        drain("wrap", 200);
    endtask

    task automatic test_back_to_back();
        int cycles;
        do_reset();
        push_tags(12'h200, 15);
        cycles = 0;
        while (cq_ready !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        checks++;
        if (cq_ready !== 1'b1 || cq_out !== 12'h200) begin
            errors++;
            $display("FAIL b2b_head: ready=%b out=%h required 1/200", cq_ready, cq_out);
        end
        cq_in  = 12'h777;
        cq_enq = 1'b1;
        cq_deq = 1'b1;
        step();
        cq_enq = 1'b0;
        cq_deq = 1'b0;
        checks++;
        if (cq_full !== 1'b1 || cq_out !== 12'h201 || cq_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_swap: full=%b out=%h ready=%b required 1/201/1", cq_full, cq_out, cq_ready);
        end
`ifdef BO_DQ_STATS_EN
        checks++;
        if (dq_drop_cnt !== 16'd0 || dq_occupancy !== 4'd15) begin
            errors++;
            $display("FAIL b2b_stats: drop=%0d occ=%0d required 0/15", dq_drop_cnt, dq_occupancy);
        end
`endif
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(12'h200 + WIDTH'(i));
        exp_q.push_back(12'h777);
        drain("b2b", 200);
    endtask

    task automatic test_time_wrap();
        int bad_j;
        do_reset();
        repeat (4090) step();
        push_and_time(12'h5A5, "twrap");
        bad_j = -1;
        for (int j = 0; j < 5000; j++) begin
            if (cq_ready !== 1'b1 && bad_j < 0) bad_j = j;
            step();
        end
        checks++;
        if (bad_j >= 0 || cq_out !== 12'h5A5) begin
            errors++;
            $display("FAIL twrap_hold: ready dropped at hold cycle %0d, out=%h, required ready throughout and 5a5", bad_j, cq_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_tags(12'h300, 2);
        repeat (40) step();
        push_tags(12'h302, 3);
        repeat (16) step();
        checks++;
        if (cq_ready !== 1'b1 || cq_out !== 12'h300) begin
            errors++;
            $display("FAIL mid_pre: ready=%b out=%h required 1/300", cq_ready, cq_out);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (cq_empty !== 1'b1 || cq_ready !== 1'b0 || cq_out !== '0 || cq_full !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: empty=%b ready=%b out=%h full=%b required 1/0/000/0", cq_empty, cq_ready, cq_out, cq_full);
        end
        step();
        rst = 1'b0;
        push_and_time(12'h3FF, "mid_after");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_delay();
        test_fill_overflow();
        test_order_wrap();
        test_back_to_back();
        test_time_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
